// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch front end with branch-prediction hookup
//
// Issues one word-aligned fetch at a time to instruction memory. The block
// waits for the response, optionally consults the branch predictor in the
// same cycle, and pushes {pc, inst, prediction, ghr} into a small FIFO
// toward decode. A redirect from execute flushes the queue and restarts
// fetch at the corrected PC. If that redirect lands while a request is
// still outstanding, the block drains the stale response.
//
// Configuration macro: FETCH_STAGE_PREDICT_EN
//   defined   -> predictor outputs are live and taken predictions steer fetch
//   undefined -> predictor outputs tied 0, fetch is strictly sequential,
//                and the queue always carries a zero GHR
//
// Parameters: GH (GHR snapshot width), FQ_DEPTH (queue entries, power of
//             two, >= 2), RESET_PC (first fetch address)
// Ports:
//   clock_i, reset_n_i                       clock, sync active-low reset
//   imem_req_valid_o/addr_o, imem_req_ready_i   fetch request channel
//   imem_resp_valid_i, imem_resp_data_i      fetch response
//   predict_req_valid_o/pc_o/used_o          predictor lookup / GHR shift
//   predict_taken_i/target_i/ghr_snapshot_i  predictor answer
//   redirect_valid_i, redirect_pc_i          flush from execute
//   fq_valid_o, fq_ready_i, fq_pc_o, fq_inst_o, fq_pred_taken_o,
//   fq_pred_target_o, fq_ghr_o               queue head toward decode
module fetch_stage #(
  parameter int          GH       = 8,
  parameter int          FQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  output logic          imem_req_valid_o,
  output logic [31:0]   imem_req_addr_o,
  input  logic          imem_req_ready_i,
  input  logic          imem_resp_valid_i,
  input  logic [31:0]   imem_resp_data_i,
  output logic          predict_req_valid_o,
  output logic [31:0]   predict_req_pc_o,
  output logic          predict_req_used_o,
  input  logic          predict_taken_i,
  input  logic [31:0]   predict_target_i,
  input  logic [GH-1:0] predict_ghr_snapshot_i,
  input  logic          redirect_valid_i,
  input  logic [31:0]   redirect_pc_i,
  output logic          fq_valid_o,
  input  logic          fq_ready_i,
  output logic [31:0]   fq_pc_o,
  output logic [31:0]   fq_inst_o,
  output logic          fq_pred_taken_o,
  output logic [31:0]   fq_pred_target_o,
  output logic [GH-1:0] fq_ghr_o
);

`ifdef FETCH_STAGE_PREDICT_EN
  localparam logic PRED_EN = 1'b1;
`else
  localparam logic PRED_EN = 1'b0;
`endif

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Queue storage carries no reset; only count/pointers qualify it.
  logic [31:0]     pc_mem_q     [FQ_DEPTH];
  logic [31:0]     inst_mem_q   [FQ_DEPTH];
  logic            taken_mem_q  [FQ_DEPTH];
  logic [31:0]     target_mem_q [FQ_DEPTH];
  logic [GH-1:0]   ghr_mem_q    [FQ_DEPTH];

  logic            resp_in_wait;
  logic            taken_eff;
  logic [31:0]     pc_plus4;
  logic [31:0]     entry_target;
  logic            enq, deq;

  // pc_q only moves on response or redirect, and any redirect leaves WAIT,
  // so while in WAIT pc_q is exactly the address of the outstanding request.
  assign pc_plus4     = pc_q + 32'd4;
  assign resp_in_wait = (state_q == WAIT) && imem_resp_valid_i;
  assign taken_eff    = PRED_EN && predict_taken_i && (predict_target_i != 32'd0);
  assign entry_target = taken_eff ? predict_target_i : pc_plus4;

  assign imem_req_valid_o = reset_n_i && (state_q == FETCH) &&
                            (count_q < DEPTH_C) && !redirect_valid_i;
  assign imem_req_addr_o  = pc_q;

  assign predict_req_valid_o = PRED_EN && reset_n_i && resp_in_wait;
  assign predict_req_used_o  = predict_req_valid_o && !redirect_valid_i;
  assign predict_req_pc_o    = predict_req_valid_o ? pc_q : 32'd0;

  assign enq = reset_n_i && resp_in_wait && !redirect_valid_i;

  assign fq_valid_o       = reset_n_i && (count_q != '0) && !redirect_valid_i;
  assign deq              = fq_valid_o && fq_ready_i;
  assign fq_pc_o          = fq_valid_o ? pc_mem_q[rd_ptr_q]     : 32'd0;
  assign fq_inst_o        = fq_valid_o ? inst_mem_q[rd_ptr_q]   : 32'd0;
  assign fq_pred_taken_o  = fq_valid_o ? taken_mem_q[rd_ptr_q]  : 1'b0;
  assign fq_pred_target_o = fq_valid_o ? target_mem_q[rd_ptr_q] : 32'd0;
  assign fq_ghr_o         = fq_valid_o ? ghr_mem_q[rd_ptr_q]    : '0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (redirect_valid_i) begin
      pc_d     = redirect_pc_i;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    case (state_q)
      FETCH: begin
        if (imem_req_valid_o && imem_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (redirect_valid_i) begin
          // Response in the same cycle is dropped; otherwise it is still in flight.
          state_d = imem_resp_valid_i ? FETCH : DRAIN;
        end else if (imem_resp_valid_i) begin
          pc_d    = taken_eff ? predict_target_i : pc_plus4;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // A redirect here only retargets the PC. The stale response is still
        // owed, and its arrival is what releases DRAIN (even alongside a
        // redirect), so the block can never wait on a response already consumed.
        if (imem_resp_valid_i) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (enq) begin
      pc_mem_q[wr_ptr_q]     <= pc_q;
      inst_mem_q[wr_ptr_q]   <= imem_resp_data_i;
      taken_mem_q[wr_ptr_q]  <= taken_eff;
      target_mem_q[wr_ptr_q] <= entry_target;
      ghr_mem_q[wr_ptr_q]    <= PRED_EN ? predict_ghr_snapshot_i : '0;
    end
  end

endmodule
